keypad_digit_entry_scanner: RTL

- Input-side counterpart to the four-digit seven-segment display path.
- Scans a 4x4 matrix keypad (Pmod KYPD layout) by driving one column low at a time and reading the active-low rows.
- Debounces presses and decodes the pressed key to a 4-bit hex code.
- Maintains a four-digit BCD entry register (thousands/hundreds/tens/ones) that the display controller can show directly.

---
 rtl/keypad_digit_entry_scanner_pkg.sv | 44 ++++
 rtl/keypad_digit_entry_scanner_row_synchronizer.sv | 27 ++
 rtl/keypad_digit_entry_scanner.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/keypad_digit_entry_scanner_pkg.sv
// Shared types and key decode for the keypad digit-entry scanner.
// Key layout follows the Pmod KYPD: columns left to right, rows top to bottom.
package keypad_pkg;

  typedef enum logic {
    RELEASED,
    PRESSED
  } scan_state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } snapshot_class_t;

  localparam logic [3:0] KEY_CLEAR     = 4'hC;
  localparam logic [3:0] KEY_BACKSPACE = 4'hE;

  function automatic logic [3:0] keymap(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] code;
    code = 4'h0;
    case ({col, row})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h4;
      4'b00_10: code = 4'h7;
      4'b00_11: code = 4'h0;
      4'b01_00: code = 4'h2;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h8;
      4'b01_11: code = 4'hF;
      4'b10_00: code = 4'h3;
      4'b10_01: code = 4'h6;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hE;
      4'b11_00: code = 4'hA;
      4'b11_01: code = 4'hB;
      4'b11_10: code = 4'hC;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_digit_entry_scanner_row_synchronizer.sv
// Two-flop synchroniser for the asynchronous keypad rows.
// Resets to all-ones so the rows read as idle (no key pressed).
module row_synchronizer #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/keypad_digit_entry_scanner.sv
// 4x4 keypad column scanner with scan-level debounce and a four-digit BCD
// entry register (shift-in for 0-9, C clears, E backspaces).
module keypad_digit_entry_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk_100_Mhz,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] thousands_digit,
  output logic [3:0] hundreds_digit,
  output logic [3:0] tens_digit,
  output logic [3:0] ones_digit
);

  localparam int TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_SCANS);

  logic [3:0] row_sync;

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        col_q, col_d;
  logic [3:0]        col_n_q, col_n_d;
  logic [15:0]       snap_q, snap_d;

  scan_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        cand_q, cand_d;

  logic              key_valid_q, key_valid_d;
  logic [3:0]        key_code_q, key_code_d;
  logic [3:0][3:0]   dig_q, dig_d;

  logic              last_tick;
  logic              scan_done;
  logic              accept;
  logic [4:0]        n_keys;
  logic [3:0]        hit_idx;
  snapshot_class_t   cls;
  logic [3:0]        scan_code;

  row_synchronizer #(
    .WIDTH (4)
  ) u_row_sync (
    .clk_i   (clk_100_Mhz),
    .reset_i (reset),
    .async_i (row_n),
    .sync_o  (row_sync)
  );

  assign last_tick = (tick_q == TICK_LAST);
  assign scan_done = last_tick && (col_q == 2'd3);

  // Sampling sits at the end of each column slot, well past synchroniser latency.
  always_comb begin
    tick_d  = last_tick ? '0 : tick_q + TICK_W'(1);
    col_d   = col_q;
    col_n_d = col_n_q;
    snap_d  = snap_q;
    if (last_tick) begin
      col_d   = col_q + 2'd1;
      col_n_d = {col_n_q[2:0], col_n_q[3]};
      snap_d[{col_q, 2'b00} +: 4] = ~row_sync;
    end
  end

  // Classify the snapshot including the column being sampled on this edge.
  always_comb begin
    n_keys  = 5'd0;
    hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap_d[i]) begin
        n_keys  = n_keys + 5'd1;
        hit_idx = 4'(i);
      end
    end
    if (n_keys == 5'd0)      cls = NONE;
    else if (n_keys == 5'd1) cls = SINGLE;
    else                     cls = MULTI;
    scan_code = keymap(hit_idx[3:2], hit_idx[1:0]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (scan_done) begin
      case (state_q)
        RELEASED: begin
          if (cls == SINGLE) begin
            if (scan_code == cand_q) begin
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              cnt_d  = CNT_W'(1);
              cand_d = scan_code;
            end
          end else begin
            cnt_d = '0;
          end
          if (cnt_d == CNT_DONE) begin
            accept  = 1'b1;
            state_d = PRESSED;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          cnt_d = (cls == NONE) ? cnt_q + CNT_W'(1) : '0;
          if (cnt_d == CNT_DONE) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_valid_d = accept;
    key_code_d  = key_code_q;
    dig_d       = dig_q;
    if (accept) begin
      key_code_d = scan_code;
      if (scan_code <= 4'd9) begin
        dig_d = {dig_q[2:0], scan_code};
      end else if (scan_code == KEY_CLEAR) begin
        dig_d = '0;
      end else if (scan_code == KEY_BACKSPACE) begin
        dig_d = {4'd0, dig_q[3:1]};
      end
    end
  end

  always_ff @(posedge clk_100_Mhz or posedge reset) begin
    if (reset) begin
      tick_q      <= '0;
      col_q       <= 2'd0;
      col_n_q     <= 4'b1110;
      snap_q      <= '0;
      state_q     <= RELEASED;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      dig_q       <= '0;
    end else begin
      tick_q      <= tick_d;
      col_q       <= col_d;
      col_n_q     <= col_n_d;
      snap_q      <= snap_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      dig_q       <= dig_d;
    end
  end

  assign col_n           = col_n_q;
  assign key_valid       = key_valid_q;
  assign key_code        = key_code_q;
  assign thousands_digit = dig_q[3];
  assign hundreds_digit  = dig_q[2];
  assign tens_digit      = dig_q[1];
  assign ones_digit      = dig_q[0];

endmodule
